// File: rtl/branch_resolve.sv
// ============================================================================
// Module   : branch_resolve
// Brief    : Execute-side checker for fetch-stage static branch predictions.
//            Queues in-flight predictions in order, compares each against the
//            resolved outcome and issues a one-cycle flush/redirect on a
//            mispredict. Optional macro BRANCH_RESOLVE_STATS_EN adds
//            saturating pop/mispredict counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve #(
    parameter int ADDR  = 32,
    parameter int DEPTH = 4,
    parameter int PTR   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pred_v_i,
    input  logic [ADDR-1:0] pred_pc_i,
    input  logic            pred_taken_i,
    input  logic [ADDR-1:0] pred_addr_i,
    output logic            pred_ready_o,
    input  logic            res_v_i,
    input  logic            res_taken_i,
    input  logic [ADDR-1:0] res_addr_i,
    output logic            redirect_v_o,
    output logic [ADDR-1:0] redirect_addr_o,
    output logic            flush_o,
    output logic [PTR:0]    count_o,
    output logic            err_o
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    output logic [15:0]     stat_total_o,
    output logic [15:0]     stat_mispred_o
`endif
);

    localparam logic [0:0]      c_RUN   = 1'b0;
    localparam logic [0:0]      c_FLUSH = 1'b1;
    localparam logic [PTR:0]    c_FULL  = (PTR+1)'(DEPTH);
    localparam logic [ADDR-1:0] c_ONE   = ADDR'(1);

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [PTR-1:0]  r_head;
    logic [PTR-1:0]  r_tail;
    logic [PTR:0]    r_count;
    logic            r_redirect_v;
    logic [ADDR-1:0] r_redirect_addr;
    logic            r_err;

    logic [ADDR-1:0] r_q_pc    [DEPTH];
    logic            r_q_taken [DEPTH];
    logic [ADDR-1:0] r_q_addr  [DEPTH];

    logic            w_run;
    logic            w_pop;
    logic            w_head_ok;
    logic            w_mispred;
    logic            w_pop_ok;
    logic            w_push;
    logic [ADDR-1:0] w_redirect_addr;

    assign w_run        = (r_state == c_RUN);
    assign pred_ready_o = w_run && (r_count != c_FULL);
    assign w_pop        = res_v_i && w_run && (r_count != '0);
    assign w_head_ok    = (r_q_taken[r_head] == res_taken_i) &&
                          (!res_taken_i || (r_q_addr[r_head] == res_addr_i));
    assign w_mispred    = w_pop && !w_head_ok;
    assign w_pop_ok     = w_pop && w_head_ok;
    // A push alongside a mispredicting pop belongs to the wrong path.
    assign w_push       = pred_v_i && pred_ready_o && !w_mispred;
    assign w_redirect_addr = res_taken_i ? res_addr_i : (r_q_pc[r_head] + c_ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_RUN:   if (w_mispred) w_state_nxt = c_FLUSH;
            c_FLUSH: w_state_nxt = c_RUN;
            default: w_state_nxt = c_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head          <= '0;
            r_tail          <= '0;
            r_count         <= '0;
            r_redirect_v    <= 1'b0;
            r_redirect_addr <= '0;
            r_err           <= 1'b0;
        end else begin
            r_redirect_v <= w_mispred;
            if (res_v_i && w_run && (r_count == '0)) begin
                r_err <= 1'b1;
            end
            if (w_mispred) begin
                r_redirect_addr <= w_redirect_addr;
                r_head          <= '0;
                r_tail          <= '0;
                r_count         <= '0;
            end else begin
                if (w_push) r_tail <= r_tail + PTR'(1);
                if (w_pop_ok) r_head <= r_head + PTR'(1);
                case ({w_push, w_pop_ok})
                    2'b10:   r_count <= r_count + (PTR+1)'(1);
                    2'b01:   r_count <= r_count - (PTR+1)'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Payload storage needs no reset: occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_tail]    <= pred_pc_i;
            r_q_taken[r_tail] <= pred_taken_i;
            r_q_addr[r_tail]  <= pred_addr_i;
        end
    end

    assign redirect_v_o    = r_redirect_v;
    assign flush_o         = r_redirect_v;
    assign redirect_addr_o = r_redirect_addr;
    assign count_o         = r_count;
    assign err_o           = r_err;

`ifdef BRANCH_RESOLVE_STATS_EN
    logic [15:0] r_stat_total;
    logic [15:0] r_stat_mispred;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_total   <= '0;
            r_stat_mispred <= '0;
        end else begin
            if (w_pop && (r_stat_total != 16'hFFFF)) begin
                r_stat_total <= r_stat_total + 16'd1;
            end
            if (w_mispred && (r_stat_mispred != 16'hFFFF)) begin
                r_stat_mispred <= r_stat_mispred + 16'd1;
            end
        end
    end

    assign stat_total_o   = r_stat_total;
    assign stat_mispred_o = r_stat_mispred;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve.sv
// ============================================================================
// Module   : tb_branch_resolve
// Brief    : Directed self-checking bench for branch_resolve.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        rst;
    logic        pred_v;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic [31:0] pred_addr;
    logic        pred_ready;
    logic        res_v;
    logic        res_taken;
    logic [31:0] res_addr;
    logic        redirect_v;
    logic [31:0] redirect_addr;
    logic        flush;
    logic [2:0]  count;
    logic        err;
`ifdef BRANCH_RESOLVE_STATS_EN
    logic [15:0] stat_total;
    logic [15:0] stat_mispred;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    branch_resolve #(.ADDR(32), .DEPTH(4), .PTR(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .pred_v_i        (pred_v),
        .pred_pc_i       (pred_pc),
        .pred_taken_i    (pred_taken),
        .pred_addr_i     (pred_addr),
        .pred_ready_o    (pred_ready),
        .res_v_i         (res_v),
        .res_taken_i     (res_taken),
        .res_addr_i      (res_addr),
        .redirect_v_o    (redirect_v),
        .redirect_addr_o (redirect_addr),
        .flush_o         (flush),
        .count_o         (count),
        .err_o           (err)
`ifdef BRANCH_RESOLVE_STATS_EN
        ,
        .stat_total_o    (stat_total),
        .stat_mispred_o  (stat_mispred)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pred(input logic v, input logic [31:0] pc, input logic tk, input logic [31:0] a);
        pred_v = v; pred_pc = pc; pred_taken = tk; pred_addr = a;
    endtask

    task automatic set_res(input logic v, input logic tk, input logic [31:0] a);
        res_v = v; res_taken = tk; res_addr = a;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_pred(1'b0, 32'h0, 1'b0, 32'h0);
        set_res(1'b0, 1'b0, 32'h0);
        tick(); tick();
        rst = 1'b0;
        tick();
        tests++;
        if (pred_ready !== 1'b1 || count !== 3'd0 || redirect_v !== 1'b0 || flush !== 1'b0 ||
            err !== 1'b0 || redirect_addr !== 32'h0) begin
            fails++;
            $display("FAIL reset_state: ready=%b count=%0d redir=%b flush=%b err=%b raddr=%h, need 1 0 0 0 0 0",
                     pred_ready, count, redirect_v, flush, err, redirect_addr);
        end
    endtask

    task automatic test_correct();
        set_pred(1'b1, 32'h10, 1'b1, 32'h40);
        tick();
        set_pred(1'b0, 32'h0, 1'b0, 32'h0);
        tests++;
        if (count !== 3'd1) begin
            fails++; $display("FAIL correct_push_count: got %0d need 1", count);
        end
        set_res(1'b1, 1'b1, 32'h40);
        tick();
        set_res(1'b0, 1'b0, 32'h0);
        tests++;
        if (count !== 3'd0 || redirect_v !== 1'b0 || flush !== 1'b0) begin
            fails++; $display("FAIL correct_pop: count=%0d redir=%b flush=%b need 0 0 0", count, redirect_v, flush);
        end
    endtask

    task automatic test_mispred_taken();
        set_pred(1'b1, 32'h20, 1'b0, 32'h0);
        tick();
        // wrong-path push held during resolve and flush cycles
        set_pred(1'b1, 32'h99, 1'b0, 32'h0);
        set_res(1'b1, 1'b1, 32'h80);
        tick();
        set_res(1'b1, 1'b0, 32'h0);
        tests++;
        if (redirect_v !== 1'b1 || flush !== 1'b1 || redirect_addr !== 32'h80 ||
            count !== 3'd0 || pred_ready !== 1'b0) begin
            fails++;
            $display("FAIL mispred_taken_redirect: redir=%b flush=%b raddr=%h count=%0d ready=%b need 1 1 80 0 0",
                     redirect_v, flush, redirect_addr, count, pred_ready);
        end
        tick();
        set_pred(1'b0, 32'h0, 1'b0, 32'h0);
        set_res(1'b0, 1'b0, 32'h0);
        tests++;
        if (redirect_v !== 1'b0 || flush !== 1'b0 || pred_ready !== 1'b1 || count !== 3'd0 ||
            redirect_addr !== 32'h80 || err !== 1'b0) begin
            fails++;
            $display("FAIL mispred_taken_after: redir=%b flush=%b ready=%b count=%0d raddr=%h err=%b need 0 0 1 0 80 0",
                     redirect_v, flush, pred_ready, count, redirect_addr, err);
        end
    endtask

    task automatic test_mispred_not_taken();
        set_pred(1'b1, 32'h30, 1'b1, 32'h50);
        tick();
        set_pred(1'b0, 32'h0, 1'b0, 32'h0);
        set_res(1'b1, 1'b0, 32'h0);
        tick();
        set_res(1'b0, 1'b0, 32'h0);
        tests++;
        if (redirect_v !== 1'b1 || redirect_addr !== 32'h31) begin
            fails++; $display("FAIL mispred_fallthrough: redir=%b raddr=%h need 1 31", redirect_v, redirect_addr);
        end
        tick();
        // fall-through address wraps modulo 2^32
        set_pred(1'b1, 32'hFFFF_FFFF, 1'b1, 32'h5);
        tick();
        set_pred(1'b0, 32'h0, 1'b0, 32'h0);
        set_res(1'b1, 1'b0, 32'h0);
        tick();
        set_res(1'b0, 1'b0, 32'h0);
        tests++;
        if (redirect_v !== 1'b1 || redirect_addr !== 32'h0) begin
            fails++; $display("FAIL mispred_pc_wrap: redir=%b raddr=%h need 1 0", redirect_v, redirect_addr);
        end
        tick();
    endtask

    task automatic test_full_wrap();
        for (int i = 0; i < 4; i++) begin
            set_pred(1'b1, 32'h100 + i, 1'b1, 32'h200 + i);
            tick();
        end
        tests++;
        if (count !== 3'd4 || pred_ready !== 1'b0) begin
            fails++; $display("FAIL full_flag: count=%0d ready=%b need 4 0", count, pred_ready);
        end
        set_pred(1'b1, 32'h104, 1'b1, 32'h204);
        tick();
        tests++;
        if (count !== 3'd4) begin
            fails++; $display("FAIL full_push_dropped: count=%0d need 4", count);
        end
        set_res(1'b1, 1'b1, 32'h200);
        tick();
        tests++;
        if (count !== 3'd3 || redirect_v !== 1'b0) begin
            fails++; $display("FAIL full_pop_push_rejected: count=%0d redir=%b need 3 0", count, redirect_v);
        end
        set_res(1'b1, 1'b1, 32'h201);
        tick();
        set_res(1'b0, 1'b0, 32'h0);
        tests++;
        if (count !== 3'd3 || redirect_v !== 1'b0) begin
            fails++; $display("FAIL push_pop_same_cycle: count=%0d redir=%b need 3 0", count, redirect_v);
        end
        set_pred(1'b1, 32'h105, 1'b1, 32'h205);
        tick();
        set_pred(1'b0, 32'h0, 1'b0, 32'h0);
        tests++;
        if (count !== 3'd4) begin
            fails++; $display("FAIL refill_count: count=%0d need 4", count);
        end
        for (int i = 2; i < 6; i++) begin
            set_res(1'b1, 1'b1, 32'h200 + i);
            tick();
            tests++;
            if (redirect_v !== 1'b0 || count !== 3'(5 - i)) begin
                fails++;
                $display("FAIL wrap_order_%0d: redir=%b count=%0d need 0 %0d", i, redirect_v, count, 5 - i);
            end
        end
        set_res(1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_empty_err();
        tests++;
        if (err !== 1'b0) begin
            fails++; $display("FAIL err_clear_before: err=%b need 0", err);
        end
        set_res(1'b1, 1'b1, 32'h123);
        tick();
        set_res(1'b0, 1'b0, 32'h0);
        tests++;
        if (err !== 1'b1 || redirect_v !== 1'b0 || count !== 3'd0) begin
            fails++; $display("FAIL err_set: err=%b redir=%b count=%0d need 1 0 0", err, redirect_v, count);
        end
        tick(); tick(); tick();
        tests++;
        if (err !== 1'b1) begin
            fails++; $display("FAIL err_sticky: err=%b need 1", err);
        end
`ifdef BRANCH_RESOLVE_STATS_EN
        tests++;
        if (stat_total !== 16'd10 || stat_mispred !== 16'd3) begin
            fails++; $display("FAIL stats: total=%0d mispred=%0d need 10 3", stat_total, stat_mispred);
        end
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tests++;
        if (err !== 1'b0 || count !== 3'd0) begin
            fails++; $display("FAIL err_reset: err=%b count=%0d need 0 0", err, count);
        end
    endtask

    task automatic test_reset_mid();
        set_pred(1'b1, 32'h40, 1'b0, 32'h0);
        tick();
        set_pred(1'b0, 32'h0, 1'b0, 32'h0);
        set_res(1'b1, 1'b1, 32'h77);
        tick();
        set_res(1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (redirect_v !== 1'b0 || redirect_addr !== 32'h0 || count !== 3'd0 || pred_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_redirect: redir=%b raddr=%h count=%0d ready=%b need 0 0 0 1",
                     redirect_v, redirect_addr, count, pred_ready);
        end
    endtask

    initial begin
        test_reset();
        test_correct();
        test_mispred_taken();
        test_mispred_not_taken();
        test_full_wrap();
        test_empty_err();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
